// File: rtl/conv_pkg.sv
// Shared constants for the 5x5 convolution datapath: kernel size, default pixel width
// and the window element ordering that the multiplier-adder array also relies on.
package conv_pkg;

  localparam int CONV_DATA_W = 9;
  localparam int K           = 5;
  localparam int WIN_SIZE    = K * K;

  // Element index of window row r (0 = oldest) and column c (0 = leftmost/oldest).
  function automatic int win_idx(input int r, input int c);
    return r * K + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image-row delay line: dout is the pixel that entered DEPTH enabled cycles ago.
module line_buffer #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streams raster pixels through four row delays and a 5x5 register window, flagging
// each window that lies entirely inside the current frame.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = CONV_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [WIN_SIZE*DATA_W-1:0] feature_out,
  output logic                       window_valid,
  output logic                       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col, cur_col, next_col;
  logic [RW-1:0]     row, cur_row, next_row;
  logic              at_window, at_last;
  logic [DATA_W-1:0] chain [K];
  logic [DATA_W-1:0] win [K][K];

  // chain[j] is the pixel from j rows above the current one, at the current column.
  assign chain[0] = pix_in;

  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    line_buffer #(
      .DEPTH (IMG_W),
      .DATA_W(DATA_W)
    ) u_lb (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (pix_valid),
      .din  (chain[j]),
      .dout (chain[j+1])
    );
  end

  // sof forces the incoming pixel to (0,0) whatever the counters currently say.
  always_comb begin
    cur_col  = sof ? '0 : col;
    cur_row  = sof ? '0 : row;
    next_col = cur_col + CW'(1);
    next_row = cur_row;
    if (cur_col == CW'(IMG_W - 1)) begin
      next_col = '0;
      next_row = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
    end
    at_window = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
    at_last   = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else begin
      window_valid <= pix_valid && at_window;
      frame_done   <= pix_valid && at_last;
      if (pix_valid) begin
        col <= next_col;
        row <= next_row;
        // Window row 0 is the oldest image row, so it takes the deepest tap.
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
          win[r][K-1] <= chain[K-1-r];
        end
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_pack_r
    for (genvar c = 0; c < K; c++) begin : g_pack_c
      assign feature_out[win_idx(r, c)*DATA_W +: DATA_W] = win[r][c];
    end
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 28, pixels per image row (>= 5).
REQ-002 SHALL have parameter IMG_H, default 28, rows per image (>= 5).
REQ-003 SHALL have parameter DATA_W, default 9, signed pixel width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-high; asserted = 1.
REQ-006 SHALL have port pix_in  input  DATA_W  raster-order pixel, two's complement.
REQ-007 SHALL have port pix_valid  input  1  pix_in accepted this cycle when 1.
REQ-008 SHALL have port sof  input  1  start of frame; qualified by pix_valid, marks pixel (0,0).
REQ-009 SHALL have port feature_out  output  25*DATA_W  5x5 window, feeds the convolution multiplier-adder array directly.
REQ-010 SHALL have port window_valid  output  1  feature_out holds a complete window this cycle.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after last pixel of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advanced only on accepted pixels.
REQ-013 SHALL on accepted pixel with col = IMG_W-1 wrap col to 0 and increment row; at row = IMG_H-1 also wrap row to 0.
REQ-014 SHALL on accepted pixel with sof = 1 treat it as (0,0) regardless of counters; counters become col=1,row=0.
REQ-015 SHALL hold 4 row-delay buffers, each IMG_W deep, chained so taps give pixels from rows r-1..r-4 at the current column.
REQ-016 SHALL hold a 5x5 register window shifted one column left per accepted pixel, new column = {row-4 tap, ..., row-1 tap, pix_in}.
REQ-017 SHALL pack feature_out element i = 5*r+c at bits [i*DATA_W+DATA_W-1 : i*DATA_W], r=0 oldest row, c=0 leftmost (oldest) column.
REQ-018 SHALL assert window_valid in the cycle after accepting pixel (row,col) with row >= 4 and col >= 4; otherwise 0.
REQ-019 SHALL produce exactly (IMG_W-4)*(IMG_H-4) window_valid pulses per frame; no window spans a row boundary.
REQ-020 SHALL latency: window for pixel accepted at cycle t presented at cycle t+1; feature_out and window_valid registered.
REQ-021 SHALL with pix_valid = 0 hold all buffers, window, counters; window_valid = 0 that cycle; feature_out holds last value.
REQ-022 SHALL pulse frame_done in the cycle after accepting pixel (IMG_H-1, IMG_W-1), coincident with last window_valid.
REQ-023 SHALL on sof mid-frame abandon the partial frame: no frame_done, no windows until row 4 of new frame; stale buffer data never reaches a valid window.
REQ-024 SHALL accept back-to-back pixels every cycle with no bubbles; there is no backpressure.

Reset
REQ-025 SHALL on rst_n = 1 at a rising edge clear col, row, window registers, feature_out to 0, window_valid and frame_done to 0.
REQ-026 SHALL not require line buffer contents cleared; reset-then-first-frame windows are correct by REQ-018 gating.
REQ-027 SHALL give reset priority over pix_valid and sof in the same cycle; that pixel is discarded.

Structure
REQ-028 SHALL take DATA_W default, K=5, and window index mapping constants from shared package conv_pkg, also used by the multiplier-adder array.
REQ-029 SHALL implement each row delay as one sub-module line_buffer (parameters DEPTH, DATA_W; ports clk, rst_n, en, din, dout), instantiated 4 times.
REQ-030 SHALL have no combinational path from inputs to outputs.

Verification
REQ-031 IMG_W=IMG_H=8, pixel=8*row+col streamed continuously -> first window_valid cycle after pixel 36; element 0 = 0, element 12 = 18, element 24 = 36.
REQ-032 Same frame -> exactly 16 window_valid pulses, last with element 24 = 63, frame_done coincident, then 0.
REQ-033 Same frame with pix_valid deasserted every 3rd cycle -> identical window sequence and values to REQ-031/032, window_valid only after accepted pixels.
REQ-034 Reset asserted after pixel 40 then new frame with sof -> outputs 0 during reset; new frame gives 16 correct windows, none containing pre-reset data.
REQ-035 sof issued at pixel 45 of a frame -> no frame_done for old frame; next window_valid only after new-frame pixel (4,4).
REQ-036 Two frames back-to-back without gap, second pixel=100+index -> 32 windows total, two frame_done pulses, second frame element 24 first = 136.
